// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DONE,
    ST_DRAIN
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Context of the outstanding load, needed when read data returns.
  typedef struct packed {
    logic [2:0] ld_sel;
    logic [1:0] off;
  } lsu_ctx_t;

  // Byte offset used for the access; sub-size low bits are ignored.
  function automatic logic [1:0] align_off(input logic [3:0] bmask, input logic [1:0] a);
    if (bmask == BE_WORD)      return 2'b00;
    else if (bmask == BE_HALF) return {a[1], 1'b0};
    else                       return a;
  endfunction

  function automatic logic misaligned(input logic [3:0] bmask, input logic [1:0] a);
    return ((bmask == BE_HALF) && a[0]) || ((bmask == BE_WORD) && (a != 2'b00));
  endfunction

  // Replicate store data across every lane it could occupy.
  function automatic logic [31:0] store_lanes(input logic [3:0] bmask, input logic [31:0] d);
    if (bmask == BE_BYTE)      return {4{d[7:0]}};
    else if (bmask == BE_HALF) return {2{d[15:0]}};
    else                       return d;
  endfunction

endpackage

// File: rtl/lsu_ld_fmt.sv
// Load data formatter: shift the addressed lane down and sign/zero extend.
module lsu_ld_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_sel,
  output logic [31:0] data_c
);

  logic [31:0] sh;

  always_comb begin
    sh     = rdata >> {off, 3'b000};
    data_c = sh;
    case (ld_sel)
      LD_LB:   data_c = {{24{sh[7]}}, sh[7:0]};
      LD_LH:   data_c = {{16{sh[15]}}, sh[15:0]};
      LD_LBU:  data_c = {24'h0, sh[7:0]};
      LD_LHU:  data_c = {16'h0, sh[15:0]};
      default: data_c = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: req/gnt/rvalid handshake to data memory, store lane
// alignment and load formatting. Optional LSU_MISALIGN_CHECK_EN adds misalign_M.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          insn_vld_M,
  input  logic          mem_rd_en_M,
  input  logic          mem_wr_en_M,
  input  logic [3:0]    bmask_M,
  input  logic [2:0]    ld_sel_M,
  input  logic [31:0]   alu_data_M,
  input  logic [DW-1:0] rs2_data_M,
  input  logic          flush_M,
  input  logic          pipe_adv,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] ld_data_M,
  output logic          lsu_stall
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic          misalign_M
`endif
);

  assert property (@(posedge clk) DW == 32);

  lsu_state_e  state;
  lsu_ctx_t    ctx;
  logic        access_c;
  logic [1:0]  off_c;
  logic [31:0] fmt_c;

  assign access_c = insn_vld_M & (mem_rd_en_M | mem_wr_en_M) & ~flush_M;
  assign off_c    = align_off(bmask_M, alu_data_M[1:0]);

`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_c;
  assign mis_c = misaligned(bmask_M, alu_data_M[1:0]);
`endif

  lsu_ld_fmt u_ld_fmt (
    .rdata  (dmem_rdata),
    .off    (ctx.off),
    .ld_sel (ctx.ld_sel),
    .data_c (fmt_c)
  );

  // Stall holds EX/ME until the access no longer needs the instruction.
  always_comb begin
    lsu_stall = 1'b0;
    case (state)
      ST_IDLE:        lsu_stall = access_c;
      ST_REQ, ST_RSP: lsu_stall = 1'b1;
      default:        lsu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ctx        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      ld_data_M  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_M <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (access_c) begin
            ctx        <= '{ld_sel: ld_sel_M, off: off_c};
            state      <= ST_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_wr_en_M;
            dmem_addr  <= {alu_data_M[AW-1:2], 2'b00};
            dmem_be    <= 4'(bmask_M << off_c);
            dmem_wdata <= store_lanes(bmask_M, rs2_data_M);
`ifdef LSU_MISALIGN_CHECK_EN
            // Misaligned accesses never reach the bus.
            if (mis_c) begin
              state      <= ST_DONE;
              dmem_req   <= 1'b0;
              misalign_M <= 1'b1;
              ld_data_M  <= '0;
            end
`endif
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            // A granted store is committed even if flushed; a granted load
            // still owes one rvalid that must be drained.
            if (dmem_we) state <= flush_M ? ST_IDLE : ST_DONE;
            else         state <= flush_M ? ST_DRAIN : ST_RSP;
          end else if (flush_M) begin
            dmem_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_RSP: begin
          if (dmem_rvalid) begin
            if (flush_M) begin
              state <= ST_IDLE;
            end else begin
              ld_data_M <= fmt_c;
              state     <= ST_DONE;
            end
          end else if (flush_M) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (pipe_adv || flush_M) begin
            state <= ST_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_M <= 1'b0;
`endif
          end
        end
        ST_DRAIN: begin
          if (dmem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
